gf_mul_seq: RTL and testbench

Parametrised, digit-serial GF(2^WIDTH) multiplier with a configurable reduction polynomial and valid/ready handshakes on input and output. It generalises the fixed 4-bit, x^4+x+1, purely combinational field multiplier to any field width and polynomial. It trades latency for area by processing DIGIT multiplier bits per cycle. It serves the S-box inversion, MixColumns and key-expansion datapaths, and any GF(2^8) or GF(2^4) arithmetic the accelerator needs.

---
 rtl/gf_mul_seq.sv | 118 +++++++++++
 tb/tb_gf_mul_seq.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : gf_mul_seq
// Description : Digit-serial GF(2^WIDTH) multiplier, MSB-first Horner scheme,
//               DIGIT multiplier bits per cycle, valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module gf_mul_seq #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH:0]   POLY  = 9'h11B,
    parameter int               DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int c_steps = WIDTH / DIGIT;
    localparam int c_cw    = (c_steps > 1) ? $clog2(c_steps) : 1;

    generate
        if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0 || POLY[WIDTH] != 1'b1)
        begin : g_param_check
            $fatal(1, "gf_mul_seq: illegal WIDTH/DIGIT/POLY combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_acc;
    logic [c_cw-1:0]   r_cnt;
    logic [WIDTH-1:0]  r_out_data;
    logic              r_out_valid;
    logic [WIDTH-1:0]  w_acc_nxt;
    logic              w_last;

    function automatic logic [WIDTH-1:0] xtime(input logic [WIDTH-1:0] v);
        xtime = {v[WIDTH-2:0], 1'b0} ^ (v[WIDTH-1] ? POLY[WIDTH-1:0] : '0);
    endfunction

    // Horner step over the top DIGIT bits of the remaining multiplier
    always_comb begin
        w_acc_nxt = r_acc;
        for (int i = 0; i < DIGIT; i++) begin
            w_acc_nxt = xtime(w_acc_nxt) ^ (r_b[WIDTH-1-i] ? r_a : '0);
        end
    end

    assign w_last = (r_cnt == c_cw'(c_steps - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_nxt = S_BUSY;
            S_BUSY:  if (w_last)    w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default:                w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a   <= in_a;
                        r_b   <= in_b;
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                S_BUSY: begin
                    r_acc <= w_acc_nxt;
                    r_b   <= r_b << DIGIT;
                    r_cnt <= r_cnt + c_cw'(1);
                    if (w_last) begin
                        r_out_data  <= w_acc_nxt;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) r_out_valid <= 1'b0;
                end
                default: r_out_valid <= 1'b0;
            endcase
        end
    end

    // Gated by rst so nothing can be accepted in a reset cycle
    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_gf_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_gf_mul_seq
// Description : Self-checking bench: three gf_mul_seq configurations against a
//               carry-less-multiply-then-divide reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gf_mul_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       iv     [3];
    logic [7:0] ia     [3];
    logic [7:0] ib     [3];
    logic       ir     [3];
    logic       ov     [3];
    logic [7:0] od     [3];
    logic       ordy_m [3];
    logic       ordy   [3];
    logic       soak;
    logic       rnd;
    logic       ii_chk;

    logic       ir0, ir1, ir2, ov0, ov1, ov2;
    logic [7:0] od0, od2;
    logic [3:0] od1;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int lat_n [3]   = '{8, 2, 2};

    always @(posedge clk) rnd <= 1'($urandom_range(0, 1));

    always_comb begin
        ordy[0] = ordy_m[0];
        ordy[1] = ordy_m[1];
        ordy[2] = soak ? rnd : ordy_m[2];
        ir[0] = ir0; ir[1] = ir1; ir[2] = ir2;
        ov[0] = ov0; ov[1] = ov1; ov[2] = ov2;
        od[0] = od0; od[1] = {4'h0, od1}; od[2] = od2;
    end

    gf_mul_seq #(.WIDTH(8), .POLY(9'h11B), .DIGIT(1)) u0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir0),
        .in_a(ia[0]), .in_b(ib[0]), .out_valid(ov0), .out_ready(ordy[0]), .out_data(od0));

    gf_mul_seq #(.WIDTH(4), .POLY(5'h13), .DIGIT(2)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir1),
        .in_a(ia[1][3:0]), .in_b(ib[1][3:0]), .out_valid(ov1), .out_ready(ordy[1]), .out_data(od1));

    gf_mul_seq #(.WIDTH(8), .POLY(9'h11B), .DIGIT(4)) u2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir2),
        .in_a(ia[2]), .in_b(ib[2]), .out_valid(ov2), .out_ready(ordy[2]), .out_data(od2));

    // Polynomial product followed by long division by the field polynomial
    function automatic logic [7:0] model(input int k, input logic [7:0] a, input logic [7:0] b);
        int          w;
        logic [15:0] p;
        logic [15:0] poly;
        w    = (k == 1) ? 4 : 8;
        poly = (k == 1) ? 16'h13 : 16'h11B;
        if (w == 4) begin
            a = a & 8'h0F;
            b = b & 8'h0F;
        end
        p = '0;
        for (int i = 0; i < w; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 2 * w - 2; i >= w; i--)
            if (p[i]) p = p ^ (poly << (i - w));
        return p[7:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare process
    logic [7:0] expq [3][$];
    int         hsq  [3][$];
    int         last_hs  [3];
    logic       have_last[3] = '{1'b0, 1'b0, 1'b0};
    logic       pv  [3] = '{1'b0, 1'b0, 1'b0};
    logic       pr  [3] = '{1'b0, 1'b0, 1'b0};
    logic [7:0] pod [3] = '{8'h0, 8'h0, 8'h0};
    logic       prst = 1'b1;

    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                expq[k].delete();
                hsq[k].delete();
                have_last[k] = 1'b0;
                chk("in_ready_during_rst", 32'(ir[k]), 32'd0);
            end else begin
                if (pv[k] && !pr[k] && !prst) begin
                    chk("held_out_valid", 32'(ov[k]), 32'd1);
                    chk("held_out_data", 32'(od[k]), 32'(pod[k]));
                end
                if (ov[k]) chk("in_ready_while_done", 32'(ir[k]), 32'd0);
                if (ov[k] && !pv[k]) begin
                    chk("pending_on_valid", 32'(hsq[k].size()), 32'd1);
                    if (hsq[k].size() > 0)
                        chk("latency", 32'(cyc - hsq[k].pop_front()), 32'(lat_n[k] + 1));
                end
                if (ov[k] && ordy[k]) begin
                    chk("result_expected", 32'(expq[k].size() > 0), 32'd1);
                    if (expq[k].size() > 0)
                        chk("result", 32'(od[k]), 32'(expq[k].pop_front()));
                end
                if (iv[k] && ir[k]) begin
                    expq[k].push_back(model(k, ia[k], ib[k]));
                    hsq[k].push_back(cyc);
                    if (ii_chk && have_last[k])
                        chk("interval", 32'(cyc - last_hs[k]), 32'(lat_n[k] + 2));
                    last_hs[k]   = cyc;
                    have_last[k] = ii_chk;
                end
            end
            pv[k]  = ov[k];
            pr[k]  = ordy[k];
            pod[k] = od[k];
        end
        prst = rst;
    end

    // Driver tasks: all entered and left at posedge + 1
    task automatic send(input int k, input logic [7:0] a, input logic [7:0] b, input bit keep);
        int t = 0;
        iv[k] = 1'b1;
        ia[k] = a;
        ib[k] = b;
        @(negedge clk);
        while (!ir[k] && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("in_ready_seen", 32'(ir[k]), 32'd1);
        @(posedge clk); #1;
        if (!keep) iv[k] = 1'b0;
    endtask

    task automatic get(input int k, output logic [7:0] d);
        int t = 0;
        @(negedge clk);
        while (!(ov[k] && ordy[k]) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("out_valid_seen", 32'(ov[k]), 32'd1);
        d = od[k];
        @(posedge clk); #1;
    endtask

    task automatic do_op(input int k, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp, input string name);
        logic [7:0] d;
        send(k, a, b, 1'b0);
        get(k, d);
        chk(name, 32'(d), 32'(exp));
    endtask

    initial begin
        logic [7:0] d;
        rst = 1'b1; soak = 1'b0; ii_chk = 1'b0;
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; ia[k] = '0; ib[k] = '0; ordy_m[k] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("reset_out_valid", 32'(ov[k]), 32'd0);
            chk("reset_out_data", 32'(od[k]), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk("ready_after_reset", 32'(ir[k]), 32'd1);
        @(posedge clk); #1;

        do_op(0, 8'h57, 8'h83, 8'hC1, "w8d1_57x83");
        do_op(0, 8'h57, 8'h13, 8'hFE, "w8d1_57x13");
        do_op(1, 8'h03, 8'h07, 8'h09, "w4d2_3x7");
        do_op(1, 8'h0F, 8'h0F, 8'h0A, "w4d2_fxf");
        do_op(2, 8'h01, 8'hA5, 8'hA5, "w8d4_identity");
        do_op(2, 8'h00, 8'hFF, 8'h00, "w8d4_zero");

        // Full GF(2^4) sweep, back-to-back with out_ready held high
        ii_chk = 1'b1;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                send(1, 8'(a), 8'(b), 1'b1);
        iv[1] = 1'b0;
        ii_chk = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // Backpressure: result must sit still while stray in_valid pulses are ignored
        ordy_m[0] = 1'b0;
        send(0, 8'h57, 8'h13, 1'b0);
        begin
            int t = 0;
            @(negedge clk);
            while (!ov[0] && t < 50) begin
                @(negedge clk);
                t++;
            end
        end
        for (int j = 0; j < 10; j++) begin
            @(posedge clk); #1;
            iv[0] = 1'(j % 2);
            ia[0] = 8'($urandom);
            ib[0] = 8'($urandom);
            @(negedge clk);
            chk("bp_in_ready", 32'(ir[0]), 32'd0);
            chk("bp_out_data", 32'(od[0]), 32'hFE);
        end
        @(posedge clk); #1;
        iv[0] = 1'b0;
        ordy_m[0] = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 32'(ov[0]), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_ready_after", 32'(ir[0]), 32'd1);
        chk("bp_valid_cleared", 32'(ov[0]), 32'd0);
        @(posedge clk); #1;

        // Reset in the 3rd BUSY cycle
        send(0, 8'h57, 8'h83, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_out_valid", 32'(ov[0]), 32'd0);
        chk("midrst_out_data", 32'(od[0]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready", 32'(ir[0]), 32'd1);
        @(posedge clk); #1;
        do_op(0, 8'h57, 8'h83, 8'hC1, "after_rst_57x83");

        // Random soak with random out_ready stalls
        soak = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            send(2, 8'($urandom), 8'($urandom), 1'b0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end
        soak = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("drained_results", 32'(expq[k].size()), 32'd0);
            chk("drained_handshakes", 32'(hsq[k].size()), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
